// File: rtl/dcache_mem_stage.sv
// Direct-mapped, write-through, no-write-allocate data cache for the MEM pipeline stage.
// Defining DCACHE_STATS_EN adds saturating hit_count / miss_count outputs.
module dcache_mem_stage #(
    parameter int unsigned INDEX_BITS = 4,
    parameter int unsigned TAG_BITS   = 32 - 4 - INDEX_BITS
) (
    input  logic         clock,
    input  logic         rst,
    input  logic [31:0]  address,
    input  logic [31:0]  write_data,
    input  logic         memRead,
    input  logic         memWrite,
    input  logic         word,
    output logic [31:0]  read_data,
    output logic         stall,
    output logic         mem_req,
    output logic         mem_we,
    output logic [31:0]  mem_addr,
    output logic [31:0]  mem_wdata,
    output logic [3:0]   mem_be,
    input  logic         mem_ready,
    input  logic [127:0] mem_rdata
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]  hit_count,
    output logic [31:0]  miss_count
`endif
);

    localparam int unsigned LINES = 1 << INDEX_BITS;

    typedef logic [3:0][3:0][7:0] line_t;
    typedef enum logic [1:0] {IDLE, REFILL, FILL, WRITE} state_e;

    state_e                state_q, state_d;
    logic [LINES-1:0]      valid_q;
    logic [TAG_BITS-1:0]   tag_q  [LINES];
    line_t                 data_q [LINES];
    line_t                 line_q;
    logic                  wr_done_q, wr_done_d;

    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic [31:0]           mem_addr_q, mem_addr_d;
    logic [3:0][7:0]       mem_wdata_q, mem_wdata_d;
    logic [3:0]            mem_be_q, mem_be_d;

    logic [INDEX_BITS-1:0] idx;
    logic [TAG_BITS-1:0]   tag;
    logic [1:0]            word_sel;
    logic [1:0]            lane;
    logic                  hit;
    logic                  st_req;
    logic                  ld_req;
    line_t                 cur_line;
    line_t                 merge_line;

    assign idx      = address[3+INDEX_BITS:4];
    assign tag      = address[31:4+INDEX_BITS];
    assign word_sel = address[3:2];
    assign lane     = address[1:0];
    assign cur_line = data_q[idx];
    assign hit      = valid_q[idx] && (tag_q[idx] == tag);

    // The store stays on the inputs for one cycle after WRITE completes while
    // the pipeline advances; wr_done_q keeps it from being issued a second time.
    assign st_req = (state_q == IDLE) && !wr_done_q && memWrite;
    assign ld_req = (state_q == IDLE) && memRead && !memWrite;

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (st_req) begin
                    state_d = WRITE;
                end else if (ld_req && !hit) begin
                    state_d = REFILL;
                end
            end
            REFILL: if (mem_ready) state_d = FILL;
            FILL:   state_d = IDLE;
            WRITE:  if (mem_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        stall     = rst && ((state_q != IDLE) || st_req || (ld_req && !hit));
        read_data = '0;
        if (rst && ld_req && hit) begin
            read_data = word ? cur_line[word_sel] : {24'b0, cur_line[word_sel][lane]};
        end
    end

    always_comb begin
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        wr_done_d   = (state_q == WRITE) && mem_ready;
        if (state_q == IDLE && state_d == REFILL) begin
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b0;
            mem_addr_d  = {address[31:4], 4'b0};
            mem_wdata_d = '0;
            mem_be_d    = '0;
        end else if (state_q == IDLE && state_d == WRITE) begin
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b1;
            mem_addr_d  = address;
            mem_wdata_d = word ? write_data : {4{write_data[7:0]}};
            mem_be_d    = word ? 4'b1111 : (4'b0001 << lane);
        end else if ((state_q == REFILL || state_q == WRITE) && mem_ready) begin
            mem_req_d   = 1'b0;
            mem_we_d    = 1'b0;
            mem_addr_d  = '0;
            mem_wdata_d = '0;
            mem_be_d    = '0;
        end
    end

    always_comb begin
        merge_line = cur_line;
        for (int unsigned b = 0; b < 4; b++) begin
            if (mem_be_q[b[1:0]]) begin
                merge_line[word_sel][b[1:0]] = mem_wdata_q[b[1:0]];
            end
        end
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            wr_done_q   <= 1'b0;
            valid_q     <= '0;
            line_q      <= '0;
        end else begin
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            wr_done_q   <= wr_done_d;
            if (state_q == REFILL && mem_ready) begin
                line_q <= mem_rdata;
            end
            if (state_q == FILL) begin
                valid_q[idx] <= 1'b1;
            end
        end
    end

    // Tag and data arrays need no reset: valid_q alone qualifies them.
    always_ff @(posedge clock) begin
        if (state_q == FILL) begin
            data_q[idx] <= line_q;
            tag_q[idx]  <= tag;
        end else if (state_q == WRITE && mem_ready && hit) begin
            data_q[idx] <= merge_line;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;
    logic        fill_done_q;

    // The post-refill hit completes a load that already counted as a miss.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
            fill_done_q <= 1'b0;
        end else begin
            fill_done_q <= (state_q == FILL);
            if (ld_req && hit && !fill_done_q && hit_cnt_q != '1) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if (state_q == IDLE && state_d == REFILL && miss_cnt_q != '1) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`endif

endmodule

// File: doc/dcache_mem_stage.md
Name: dcache_mem_stage

Overview:
- Direct-mapped, write-through, no-write-allocate data cache in the memory stage.
- Sits between the ex_mem flip-flop and the mem_wb flip-flop, alongside the memory stage.
- Serves loads from cache on a hit. Refills a 16-byte line from main memory on a load miss. Forwards every store to main memory.
- Asserts stall so the pipeline holds ex_mem while a miss or store is in progress.

Parameters:
INDEX_BITS, 4, log2 of line count (16 lines × 16 bytes = 256 B)
TAG_BITS, 24, derived as 32-4-INDEX_BITS; must not be overridden

Ports:
clock  in  1  pipeline clock, rising edge
rst  in  1  asynchronous, active-low reset
address  in  32  byte address (result_EXMEM)
write_data  in  32  store data (readData2_EXMEM)
memRead  in  1  load request
memWrite  in  1  store request
word  in  1  1 = 32-bit access, 0 = byte access
read_data  out  32  load data to mem_wb
stall  out  1  hold pipeline (PC, if_id, id_ex, ex_mem)
mem_req  out  1  main-memory request
mem_we  out  1  1 = write request, 0 = line read
mem_addr  out  32  request address (line-aligned for reads)
mem_wdata  out  32  store data, byte lanes per mem_be
mem_be  out  4  byte enables for writes
mem_ready  in  1  one-cycle completion pulse from main memory
mem_rdata  in  128  refill line, word 0 in bits [31:0]

Behaviour:
- Address split: offset = address[3:0], index = address[3+INDEX_BITS:4], tag = address[31:4+INDEX_BITS].
- Word accesses ignore address[1:0]. Byte lane = address[1:0], little-endian.
- Storage per line: valid bit, tag, 128-bit data.
- FSM states: IDLE, REFILL, FILL, WRITE.
- IDLE:
  - memWrite=1: stall=1 combinationally; next state WRITE. memWrite takes priority over memRead when both are set.
  - memRead=1 and hit: read_data valid combinationally, stall=0, zero-cycle added latency.
  - memRead=1 and miss: stall=1 combinationally; next state REFILL.
  - No request: read_data=0, stall=0.
- REFILL:
  - mem_req=1, mem_we=0, mem_addr={address[31:4],4'b0}, stall=1.
  - Hold until mem_ready=1, then latch mem_rdata and go to FILL.
- FILL:
  - Write the line, set valid, store the tag; stall=1; next state IDLE.
  - The access then hits in IDLE, so a load miss costs memory latency + 2 cycles of stall.
- WRITE:
  - mem_req=1, mem_we=1, mem_addr=address, stall=1.
  - Word store: mem_be=4'b1111, mem_wdata=write_data.
  - Byte store: mem_be=one-hot lane, write_data[7:0] replicated on all four lanes.
  - On mem_ready: if the line is a hit, merge the enabled bytes into the cached line. Misses do not allocate. Go to IDLE with stall=0 in the following cycle.
- Byte loads: zero-extend the selected byte into read_data[7:0].
- mem_req, mem_we, mem_addr, mem_wdata and mem_be are registered. They remain stable from assertion until the cycle mem_ready is sampled high, then drop the next cycle.
- mem_ready seen in IDLE or FILL is ignored.
- Upstream holds address, memRead, memWrite, word and write_data stable while stall=1.
- Reset (rst=0, any state, including mid-refill):
  - All valid bits cleared, state=IDLE.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0, stall=0, read_data=0.
  - Counters cleared.
  - A mem_ready arriving after reset release, from a request abandoned by reset, is ignored.
- Index wrap: addresses 0x000 and 0x100 map to the same line; the later refill evicts the earlier one.

Optional Feature:
- Macro: DCACHE_STATS_EN.
- When defined:
  - Adds outputs hit_count[31:0] and miss_count[31:0].
  - hit_count increments once per load completed from IDLE without a miss.
  - miss_count increments once per REFILL entry.
  - Counters saturate at 32'hFFFFFFFF and clear on reset.
- When undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Load word 0x0000_0040 after reset, memory returns line {0x44,0x33,0x22,0x11} after 3 cycles -> stall high for 5 cycles, mem_addr=0x40, then read_data=0x11; repeat load of 0x44 -> read_data=0x22, stall=0.
- Byte store 0xAB to 0x0000_0042 on a cached line -> mem_be=4'b0100, mem_wdata=0xABABABAB; following word load of 0x40 -> read_data=0x00AB0011 with no refill.
- Store to an uncached address 0x0000_0200 -> write issued, no allocation; load of 0x200 afterwards -> miss and refill (with DCACHE_STATS_EN: miss_count +1).
- Load 0x000, then 0x100, then 0x000 -> three refills, each with stall high; the final read returns data from the third refill.
- Assert rst=0 during REFILL, release, send a stray mem_ready -> mem_req=0, stall=0, no line becomes valid; next load of the same address misses.
- memRead=1 and memWrite=1 together at address 0x80 -> store path taken (mem_we=1), no refill issued.
